// File: rtl/character_action_executor.sv
// Per-player action executor: turns the character state/counter into a
// horizontal position, an attack phase, a hitbox window and one hit pulse
// per attack instance.
module character_action_executor #(
  parameter int X_WIDTH       = 10,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 575,
  parameter int X_INIT        = 100,
  parameter bit FACING_RIGHT  = 1'b1,
  parameter int FWD_STEP      = 3,
  parameter int BWD_STEP      = 2,
  parameter int DIR_STEP      = 4,
  parameter int ATK_ACT_START = 5,
  parameter int ATK_ACT_END   = 7,
  parameter int DIR_ACT_START = 4,
  parameter int DIR_ACT_END   = 6
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               i_frame_tick,
  input  logic [2:0]         i_state,
  input  logic [4:0]         i_count,
  input  logic               i_push_block,
  input  logic               i_hit_overlap,
  output logic [X_WIDTH-1:0] o_x,
  output logic [1:0]         o_phase,
  output logic               o_hitbox_active,
  output logic               o_hit,
  output logic               o_hit_kind
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BACKWARD   = 3'd1,
    ST_FORWARD    = 3'd2,
    ST_ATTACK     = 3'd3,
    ST_DIR_ATTACK = 3'd4
  } char_state_e;

  typedef enum logic [1:0] {
    PH_NONE     = 2'd0,
    PH_STARTUP  = 2'd1,
    PH_ACTIVE   = 2'd2,
    PH_RECOVERY = 2'd3
  } phase_e;

  // Two guard bits so a step below zero or past the top stays representable.
  localparam int W = X_WIDTH + 2;

  localparam logic [4:0] ATK_S = 5'(ATK_ACT_START);
  localparam logic [4:0] ATK_E = 5'(ATK_ACT_END);
  localparam logic [4:0] DIR_S = 5'(DIR_ACT_START);
  localparam logic [4:0] DIR_E = 5'(DIR_ACT_END);

  // Signed per-state displacement with the facing direction folded in.
  localparam int FWD_D = FACING_RIGHT ? FWD_STEP : -FWD_STEP;
  localparam int BWD_D = FACING_RIGHT ? -BWD_STEP : BWD_STEP;
  localparam int DIR_D = FACING_RIGHT ? DIR_STEP : -DIR_STEP;

  localparam logic signed [W-1:0] X_MIN_S = W'(X_MIN);
  localparam logic signed [W-1:0] X_MAX_S = W'(X_MAX);

  char_state_e         state;
  logic                is_atk;
  logic                is_dir;
  logic                is_attacking;

  phase_e              phase_d, phase_q;
  logic                hitbox_d, hitbox_q;
  logic [X_WIDTH-1:0]  x_d, x_q;
  logic signed [W-1:0] delta;
  logic signed [W-1:0] x_sum;
  logic                hit_now;
  logic                kind_changed;
  logic                hit_d, hit_q;
  logic                hit_kind_d, hit_kind_q;
  logic                hit_done_d, hit_done_q;
  logic                last_kind_d, last_kind_q;

  assign state        = char_state_e'(i_state);
  assign is_atk       = (state == ST_ATTACK);
  assign is_dir       = (state == ST_DIR_ATTACK);
  assign is_attacking = is_atk | is_dir;

  // Phase decode from the current state/count; codes 5..7 fall to NONE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    phase_d = PH_NONE;
    if (is_atk) begin
      if (i_count < ATK_S)       phase_d = PH_STARTUP;
      else if (i_count <= ATK_E) phase_d = PH_ACTIVE;
      else                       phase_d = PH_RECOVERY;
    end else if (is_dir) begin
      if (i_count < DIR_S)       phase_d = PH_STARTUP;
      else if (i_count <= DIR_E) phase_d = PH_ACTIVE;
      else                       phase_d = PH_RECOVERY;
    end
    hitbox_d = (phase_d == PH_ACTIVE);
  end

  // Frame-gated movement, then saturation to the legal position range.
  always_comb begin
    delta = '0;
    if (i_frame_tick) begin
      unique case (state)
        ST_FORWARD:    if (!i_push_block) delta = W'(FWD_D);
        ST_BACKWARD:   delta = W'(BWD_D);
        ST_DIR_ATTACK: if (!i_push_block && (i_count < DIR_S)) delta = W'(DIR_D);
        default:       delta = '0;
      endcase
    end
    x_sum = $signed({2'b00, x_q}) + delta;
    if (x_sum < X_MIN_S)      x_d = X_WIDTH'(X_MIN);
    else if (x_sum > X_MAX_S) x_d = X_WIDTH'(X_MAX);
    else                      x_d = x_sum[X_WIDTH-1:0];
  end

  // One hit per attack instance; a kind switch re-arms on the same clock.
  always_comb begin
    kind_changed = is_attacking && (is_dir != last_kind_q);
    hit_now      = (phase_d == PH_ACTIVE) && i_hit_overlap &&
                   !(hit_done_q && !kind_changed);
    hit_d        = hit_now;
    hit_kind_d   = hit_now ? is_dir : hit_kind_q;
    last_kind_d  = is_attacking ? is_dir : last_kind_q;
    hit_done_d   = hit_done_q;
    if (phase_d == PH_NONE) hit_done_d = 1'b0;
    else if (hit_now)       hit_done_d = 1'b1;
    else if (kind_changed)  hit_done_d = 1'b0;
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      x_q         <= X_WIDTH'(X_INIT);
      phase_q     <= PH_NONE;
      hitbox_q    <= 1'b0;
      hit_q       <= 1'b0;
      hit_kind_q  <= 1'b0;
      hit_done_q  <= 1'b0;
      last_kind_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      phase_q     <= phase_d;
      hitbox_q    <= hitbox_d;
      hit_q       <= hit_d;
      hit_kind_q  <= hit_kind_d;
      hit_done_q  <= hit_done_d;
      last_kind_q <= last_kind_d;
    end
  end

  assign o_x             = x_q;
  assign o_phase         = phase_q;
  assign o_hitbox_active = hitbox_q;
  assign o_hit           = hit_q;
  assign o_hit_kind      = hit_kind_q;

endmodule

// File: tb/tb_character_action_executor.sv
// Directed bench for character_action_executor with default parameters.
module tb_character_action_executor;

  logic       clk;
  logic       nRst;
  logic       i_frame_tick;
  logic [2:0] i_state;
  logic [4:0] i_count;
  logic       i_push_block;
  logic       i_hit_overlap;
  logic [9:0] o_x;
  logic [1:0] o_phase;
  logic       o_hitbox_active;
  logic       o_hit;
  logic       o_hit_kind;

  int errors = 0;
  int checks = 0;
  int hits;
  int hb_count;
  int kind_at_hit;
  int hit_count_at;

  character_action_executor dut (
    .clk             (clk),
    .nRst            (nRst),
    .i_frame_tick    (i_frame_tick),
    .i_state         (i_state),
    .i_count         (i_count),
    .i_push_block    (i_push_block),
    .i_hit_overlap   (i_hit_overlap),
    .o_x             (o_x),
    .o_phase         (o_phase),
    .o_hitbox_active (o_hitbox_active),
    .o_hit           (o_hit),
    .o_hit_kind      (o_hit_kind)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] st, input logic [4:0] cnt, input logic ft,
                        input logic pb, input logic ov);
    i_state       = st;
    i_count       = cnt;
    i_frame_tick  = ft;
    i_push_block  = pb;
    i_hit_overlap = ov;
  endtask

  task automatic do_reset();
    nRst = 1'b0;
    set_in(3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    nRst = 1'b1;
    tick();
  endtask

  initial begin
    nRst = 1'b0;
    set_in(3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #12;
    check("rst_x", 32'(o_x), 32'd100);
    check("rst_phase", 32'(o_phase), 32'd0);
    check("rst_hitbox", 32'(o_hitbox_active), 32'd0);
    check("rst_hit", 32'(o_hit), 32'd0);
    check("rst_kind", 32'(o_hit_kind), 32'd0);
    nRst = 1'b1;
    tick();

    // FORWARD 10 ticks: 100 + 10*3
    set_in(3'd2, 5'd0, 1'b1, 1'b0, 1'b0);
    repeat (10) tick();
    check("fwd_10_ticks", 32'(o_x), 32'd130);
    i_frame_tick = 1'b0;
    repeat (3) tick();
    check("fwd_no_tick_hold", 32'(o_x), 32'd130);

    // Push block suppresses forward motion
    set_in(3'd2, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    check("fwd_push_block", 32'(o_x), 32'd130);

    // Undefined state code 5 behaves as IDLE
    set_in(3'd5, 5'd6, 1'b1, 1'b0, 1'b1);
    tick();
    check("state5_x", 32'(o_x), 32'd130);
    check("state5_phase", 32'(o_phase), 32'd0);
    check("state5_hit", 32'(o_hit), 32'd0);

    // Drive to X_MIN (push_block ignored backward), then up to 3
    set_in(3'd1, 5'd0, 1'b1, 1'b1, 1'b0);
    repeat (70) tick();
    check("bwd_clamp_min", 32'(o_x), 32'd0);
    set_in(3'd2, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check("fwd_to_3", 32'(o_x), 32'd3);
    set_in(3'd1, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check("bwd_3_to_1", 32'(o_x), 32'd1);
    tick();
    check("bwd_1_to_0", 32'(o_x), 32'd0);
    tick();
    check("bwd_0_hold", 32'(o_x), 32'd0);

    // Up to X_MAX, back to 571, then 574, then clamp at 575
    set_in(3'd2, 5'd0, 1'b1, 1'b0, 1'b0);
    repeat (200) tick();
    check("fwd_clamp_max", 32'(o_x), 32'd575);
    set_in(3'd1, 5'd0, 1'b1, 1'b0, 1'b0);
    repeat (2) tick();
    check("bwd_575_to_571", 32'(o_x), 32'd571);
    set_in(3'd2, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check("fwd_571_to_574", 32'(o_x), 32'd574);
    tick();
    check("fwd_574_to_575", 32'(o_x), 32'd575);
    tick();
    check("fwd_575_hold", 32'(o_x), 32'd575);

    // ATTACK sweep: phase is one clock behind the count
    set_in(3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    hb_count = 0;
    for (int c = 0; c < 24; c++) begin
      set_in(3'd3, 5'(c), 1'b0, 1'b0, 1'b0);
      tick();
      if (c < 5)       check($sformatf("atk_phase_c%0d", c), 32'(o_phase), 32'd1);
      else if (c <= 7) check($sformatf("atk_phase_c%0d", c), 32'(o_phase), 32'd2);
      else             check($sformatf("atk_phase_c%0d", c), 32'(o_phase), 32'd3);
      if (o_hitbox_active) hb_count++;
    end
    check("atk_hitbox_clks", 32'(hb_count), 32'd3);
    check("atk_sweep_x_hold", 32'(o_x), 32'd575);

    // ATTACK with overlap held throughout: one pulse, twice over
    for (int rep = 0; rep < 2; rep++) begin
      set_in(3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      hits = 0;
      kind_at_hit = -1;
      hit_count_at = -1;
      for (int c = 0; c < 10; c++) begin
        set_in(3'd3, 5'(c), 1'b0, 1'b0, 1'b1);
        tick();
        if (o_hit) begin
          hits++;
          kind_at_hit = int'(o_hit_kind);
          hit_count_at = c;
        end
      end
      check($sformatf("atk_hits_rep%0d", rep), 32'(hits), 32'd1);
      check($sformatf("atk_hit_kind_rep%0d", rep), 32'(kind_at_hit), 32'd0);
      check($sformatf("atk_hit_at_rep%0d", rep), 32'(hit_count_at), 32'd5);
    end

    // Kind change on consecutive clocks re-arms the hit
    set_in(3'd3, 5'd5, 1'b0, 1'b0, 1'b1);
    tick();
    check("kind_chg_no_rehit", 32'(o_hit), 32'd0);
    set_in(3'd4, 5'd4, 1'b0, 1'b0, 1'b1);
    tick();
    check("kind_chg_hit", 32'(o_hit), 32'd1);
    check("kind_chg_kind", 32'(o_hit_kind), 32'd1);

    // DIR_ATTACK lunge from 100: +4 per tick during counts 0..3
    do_reset();
    for (int c = 0; c < 8; c++) begin
      set_in(3'd4, 5'(c), 1'b1, 1'b0, 1'b0);
      tick();
      if (c == 3) check("dir_lunge_16", 32'(o_x), 32'd116);
    end
    check("dir_lunge_hold", 32'(o_x), 32'd116);

    // Same lunge with push block, then a hit at count 4
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_in(3'd4, 5'(c), 1'b1, 1'b1, 1'b0);
      tick();
    end
    check("dir_push_block_x", 32'(o_x), 32'd100);
    set_in(3'd4, 5'd4, 1'b1, 1'b1, 1'b1);
    tick();
    check("dir_hit", 32'(o_hit), 32'd1);
    check("dir_hit_kind", 32'(o_hit_kind), 32'd1);
    check("dir_phase_active", 32'(o_phase), 32'd2);

    // Move off X_INIT, then reset mid-attack at count 6
    set_in(3'd2, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check("pre_rst_x", 32'(o_x), 32'd103);
    for (int c = 0; c < 7; c++) begin
      set_in(3'd3, 5'(c), 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("pre_rst_phase", 32'(o_phase), 32'd2);
    nRst = 1'b0;
    #1;
    check("mid_rst_x", 32'(o_x), 32'd100);
    check("mid_rst_phase", 32'(o_phase), 32'd0);
    check("mid_rst_hitbox", 32'(o_hitbox_active), 32'd0);
    check("mid_rst_kind", 32'(o_hit_kind), 32'd0);
    set_in(3'd3, 5'd6, 1'b0, 1'b0, 1'b1);
    #1;
    nRst = 1'b1;
    tick();
    check("post_rst_phase", 32'(o_phase), 32'd2);
    check("post_rst_hit", 32'(o_hit), 32'd1);
    check("post_rst_kind", 32'(o_hit_kind), 32'd0);
    tick();
    check("post_rst_single_hit", 32'(o_hit), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
